// File: rtl/dm_arb.sv
// rtl/dm_arb.sv - two-port data-memory arbiter with sub-word lane control and misalignment suppression
// Define DM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with p0 winning ties.
module dm_arb (
  input  logic        clk,
  input  logic        rstn,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [8:0]  p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [1:0]  p0_size,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [8:0]  p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_size,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        dm_we,
  output logic [6:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic [1:0]  dm_choice,
  output logic [31:0] dm_position,
  input  logic [31:0] dm_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      state;
  state_t      state_nxt;
  logic        any_req;
  logic        arb_fire;
  logic        win_nxt;
  logic        win;
  logic        lat_we;
  logic [8:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        illegal;

  assign any_req  = p0_req | p1_req;
  assign arb_fire = (state == S_IDLE) && any_req;

`ifdef DM_ARB_RR_EN
  logic ptr;

  // ptr names the requester that wins the next tie
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (arb_fire) begin
      ptr <= ~win_nxt;
    end
  end

  assign win_nxt = (p0_req & p1_req) ? ptr : p1_req;
`else
  assign win_nxt = ~p0_req & p1_req;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // lat_addr/lat_wdata double as dm_addr/dm_din so they hold between accesses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 9'd0;
      lat_wdata <= 32'd0;
      lat_size  <= 2'b00;
    end else if (arb_fire) begin
      win       <= win_nxt;
      lat_we    <= win_nxt ? p1_we    : p0_we;
      lat_addr  <= win_nxt ? p1_addr  : p0_addr;
      lat_wdata <= win_nxt ? p1_wdata : p0_wdata;
      lat_size  <= win_nxt ? p1_size  : p0_size;
    end
  end

  always_comb begin
    illegal = 1'b0;
    case (lat_size)
      SZ_WORD: illegal = (lat_addr[1:0] != 2'b00);
      SZ_HALF: illegal = lat_addr[0];
      SZ_RSVD: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  always_comb begin
    dm_we       = 1'b0;
    dm_choice   = 2'b00;
    dm_position = 32'd0;
    if (state == S_ACCESS) begin
      dm_we = lat_we & ~illegal;
      case (lat_size)
        SZ_BYTE: begin
          dm_choice   = 2'b01;
          dm_position = {30'd0, lat_addr[1:0]} + 32'd1;
        end
        SZ_HALF: begin
          dm_choice   = 2'b10;
          dm_position = lat_addr[1] ? 32'd3 : 32'd1;
        end
        default: begin
          dm_choice   = 2'b00;
          dm_position = 32'd0;
        end
      endcase
    end
  end

  assign dm_addr = lat_addr[8:2];
  assign dm_din  = lat_wdata;

  // the memory read port is combinational, so the word is captured as ACCESS ends
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p0_rdata <= 32'd0;
      p1_rdata <= 32'd0;
    end else if (state == S_ACCESS) begin
      if (win) begin
        p1_rdata <= dm_dout;
      end else begin
        p0_rdata <= dm_dout;
      end
    end
  end

  assign p0_gnt    = (state == S_ACCESS) && !win;
  assign p1_gnt    = (state == S_ACCESS) &&  win;
  assign p0_rvalid = (state == S_RESP)   && !win;
  assign p1_rvalid = (state == S_RESP)   &&  win;
  assign p0_err    = p0_rvalid && illegal;
  assign p1_err    = p1_rvalid && illegal;

endmodule
